vc4_frame_scheduler: RTL and testbench
======================================

# vc4_frame_scheduler

Single-buffer frame scheduler for the VC4 datapath.
- Accepts one C4 container of `LENGTH`×`WIDTH` bytes (2340) in row-major order over a valid/ready stream and stores it in a frame RAM.
- Replays the frame downstream in either row-based or column-based scan order, marking start and end of frame.
- Sits between the C4 byte source and the VC4 assembly/CSV dump stages.
- Sequences the frame RAM so only one of fill and drain runs at a time.

## Interface
Parameters:
- `LENGTH`, 260: columns per frame (`c4_Length`/`vc4_Length`).
- `WIDTH`, 9: rows per frame.
- `BYTE_W`, 8: bits per byte (`Byte_Num`).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `scan_mode_i`, in, 1: 0 = `row_based`, 1 = `col_based`. Sampled only on the WRITE→READ transition.
- `in_data_i`, in, `BYTE_W`: C4 byte.
- `in_valid_i`, in, 1: input byte valid.
- `in_ready_o`, out, 1: scheduler accepts a byte.
- `out_data_o`, out, `BYTE_W`: scheduled byte.
- `out_valid_o`, out, 1: output byte valid.
- `out_ready_i`, in, 1: downstream accepts.
- `out_sof_o`, out, 1: first byte of frame. Qualified by `out_valid_o`.
- `out_eof_o`, out, 1: last byte of frame. Qualified by `out_valid_o`.
- `frame_done_o`, out, 1: one-cycle pulse after the last output handshake.

## Operation
- Handshake rule: a transfer occurs when valid and ready are both high on a rising edge.
- Valid must stay high and data stable until the transfer.
- Frame size: N = `LENGTH`×`WIDTH` = 2340.
- Counters:
  - Linear write counter, 12 bits.
  - Read row counter, 4 bits.
  - Read column counter, 9 bits.
  - Read address register, 12 bits.
- FSM states:
  - **WRITE** (reset state):
    - `in_ready_o`=1.
    - Each input transfer writes RAM[`wr_cnt`] and increments `wr_cnt`.
    - Transfer with `wr_cnt`=N−1 → READ. The scan mode is latched and the read counters are cleared on the same edge.
  - **READ**:
    - `in_ready_o`=0.
    - The read address generator walks N addresses in the latched order.
    - Output transfer of the byte flagged `out_eof_o` → WRITE. `frame_done_o` pulses and `wr_cnt` clears.
- Address order, no multiplier:
  - Row mode: addr = 0,1,…,N−1.
  - Column mode: row varies fastest.
    - On each row step, addr += `LENGTH`.
    - When row wraps from `WIDTH`−1 to 0, addr = col+1 and col increments.
    - Sequence: 0, 260, 520, …, 2080, 1, 261, …, 2339.
- `out_sof_o` is set on the output byte read from the first address issued. `out_eof_o` is set on the byte from the N-th address issued.
- Output stage:
  - Frame RAM is synchronous-read with 1-cycle latency.
  - A 2-entry skid/output buffer guarantees no byte is lost or duplicated under any `out_ready_i` pattern.
  - A read is issued only when buffer space is guaranteed.
- Reset values:
  - `in_ready_o`=0 during reset, 1 on the first cycle after reset deasserts.
  - `out_valid_o`=0, `out_sof_o`=0, `out_eof_o`=0, `frame_done_o`=0.
  - `out_data_o`=0.
  - All counters = 0; state = WRITE.
- Boundary conditions:
  - `in_valid_i` during READ is ignored; the byte is not consumed.
  - `scan_mode_i` changes during READ have no effect until the next frame.
  - Reset asserted mid-WRITE or mid-READ:
    - The partial frame is discarded.
    - The output buffer is flushed.
    - The FSM restarts in WRITE with no SOF/EOF emitted.
  - RAM contents are not cleared by reset; they are overwritten by the next fill.

## Timing
- Input throughput in WRITE: 1 byte/cycle.
- Last input transfer at edge T: `in_ready_o`=0 from T+1.
- First output: `out_valid_o`=1 with `out_sof_o` at T+2. This is the RAM read latency plus one register.
- Output throughput in READ: 1 byte/cycle with `out_ready_i` held high; no bubbles after the first byte.
- EOF transfer at edge E:
  - `frame_done_o`=1 and `out_valid_o`=0 during cycle E+1.
  - `in_ready_o`=1 from E+1.
- Minimum frame period with no stalls: 2340 + 2340 + 2 cycles.

## Structure
- Shared package holds:
  - Dimension parameters `c4_Length`, `c4_Width`, `Byte_Num`, `vc4_Length`, `vc4_Width`.
  - Scan-order constants `row_based`/`col_based`.
  - A new enum `sched_state_t` {WRITE, READ}.
  - A derived constant for frame size N.
- Sub-module `frame_ram`:
  - Simple dual-port: 1 write port, 1 synchronous read port.
  - Depth N, width `BYTE_W`.
  - Parameterised by depth/width.
  - Inferable as block RAM.
- Address generation and the FSM stay in the top module.

## Test plan
Input stimulus for every test: byte k = k mod 256 unless stated.
- Row mode, `out_ready_i`=1:
  - Outputs 0,1,2,…, with the byte at index 2339 = 35.
  - SOF only on the first byte, EOF only on the last.
  - `frame_done_o` one cycle after EOF.
- Column mode, `out_ready_i`=1:
  - Outputs 0,4,8,12,16,20,24,28,32 (addrs 0..2080), then 1,5,…
  - Byte index 9 = 1; last byte = 35 (addr 2339) with EOF.
- Random `out_ready_i` (50%) in column mode: output sequence identical to the stalled-free run, with no drops or duplicates.
- Random `in_valid_i` gaps: exactly 2340 bytes accepted before `in_ready_o` falls; READ starts 2 cycles after the last accept.
- `scan_mode_i` toggled at output byte 100 of a row-mode frame: the remainder stays row order; the next frame uses the new mode.
- `rst_n` low for 1 cycle at output byte 500:
  - `out_valid_o`=0 next cycle, `in_ready_o`=1 after reset.
  - A fresh frame replays correctly with SOF on its first byte.

Source files
------------

// File: rtl/vc4_frame_scheduler_pkg.sv
// Shared dimensions, scan-order codes and scheduler state for the VC4 frame path.
package vc4_frame_scheduler_pkg;

  // C4 container geometry
  localparam int unsigned c4_Length  = 260;
  localparam int unsigned c4_Width   = 9;
  localparam int unsigned Byte_Num   = 8;

  // VC4 frame geometry matches the C4 payload it carries
  localparam int unsigned vc4_Length = c4_Length;
  localparam int unsigned vc4_Width  = c4_Width;

  // Scan-order codes as seen on scan_mode_i
  localparam logic row_based = 1'b0;
  localparam logic col_based = 1'b1;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } sched_state_t;

  function automatic int unsigned frame_size(input int unsigned len, input int unsigned wid);
    return len * wid;
  endfunction

  // Bytes per frame
  localparam int unsigned FrameN = frame_size(vc4_Length, vc4_Width);

endpackage

// File: rtl/vc4_frame_scheduler_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module frame_ram #(
  parameter int unsigned Depth = 2340,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port, one cycle of latency, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/vc4_frame_scheduler.sv
// Single-buffer VC4 frame scheduler: fills the frame RAM in row-major order, then replays it
// in row or column scan order through a 2-entry output buffer.
module vc4_frame_scheduler
  import vc4_frame_scheduler_pkg::*;
#(
  parameter int unsigned LENGTH = vc4_Length,
  parameter int unsigned WIDTH  = vc4_Width,
  parameter int unsigned BYTE_W = Byte_Num
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_mode_i,
  input  logic [BYTE_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [BYTE_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_sof_o,
  output logic              out_eof_o,
  output logic              frame_done_o
);

  localparam int unsigned N     = frame_size(LENGTH, WIDTH);
  localparam int unsigned AddrW = $clog2(N);
  localparam int unsigned RowW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ColW  = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  localparam logic [AddrW-1:0] LastAddr  = AddrW'(N - 1);
  localparam logic [AddrW-1:0] RowStride = AddrW'(LENGTH);
  localparam logic [RowW-1:0]  LastRow   = RowW'(WIDTH - 1);

  // FSM and counters
  sched_state_t     state_q;
  logic [AddrW-1:0] wr_cnt_q;
  logic             in_ready_q;
  logic             mode_q;
  logic             rd_active_q;
  logic             frame_done_q;
  logic [RowW-1:0]  rd_row_q, rd_row_d;
  logic [ColW-1:0]  rd_col_q, rd_col_d;
  logic [AddrW-1:0] rd_addr_q, rd_addr_d;

  // Output stage
  logic              rd_pend_q;
  logic              pend_sof_q, pend_eof_q;
  logic [BYTE_W-1:0] buf_data_q [2];
  logic              buf_sof_q  [2];
  logic              buf_eof_q  [2];
  logic              buf_rd_ptr_q, buf_wr_ptr_q;
  logic [1:0]        buf_cnt_q;

  logic [BYTE_W-1:0] ram_rdata;
  logic              wr_fire, out_valid, out_fire, eof_fire, space_ok, rd_issue;

  assign wr_fire   = in_valid_i & in_ready_q;
  assign out_valid = (buf_cnt_q != 2'd0);
  assign out_fire  = out_valid & out_ready_i;
  assign eof_fire  = out_fire & buf_eof_q[buf_rd_ptr_q];

  // Issue a read only if the buffer can hold it once it lands, counting the byte in flight
  // and any byte leaving this cycle; the pop credit is what keeps the stream bubble-free.
  always_comb begin
    space_ok = ({1'b0, buf_cnt_q} + {2'b00, rd_pend_q}) < (3'd2 + {2'b00, out_fire});
    rd_issue = (state_q == READ) & rd_active_q & space_ok;
  end

  // Next read address: linear in row mode, stride LENGTH with column wrap in column mode
  always_comb begin
    rd_row_d  = rd_row_q;
    rd_col_d  = rd_col_q;
    rd_addr_d = rd_addr_q + 1'b1;
    if (mode_q == col_based) begin
      if (rd_row_q == LastRow) begin
        rd_row_d  = '0;
        rd_col_d  = rd_col_q + 1'b1;
        rd_addr_d = AddrW'(rd_col_q) + 1'b1;
      end else begin
        rd_row_d  = rd_row_q + 1'b1;
        rd_addr_d = rd_addr_q + RowStride;
      end
    end
  end

  // Scheduler FSM: fill, then drain, never both
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= WRITE;
      wr_cnt_q     <= '0;
      in_ready_q   <= 1'b0;
      mode_q       <= row_based;
      rd_active_q  <= 1'b0;
      frame_done_q <= 1'b0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      rd_addr_q    <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        WRITE: begin
          in_ready_q <= 1'b1;
          if (wr_fire) begin
            if (wr_cnt_q == LastAddr) begin
              state_q     <= READ;
              in_ready_q  <= 1'b0;
              mode_q      <= scan_mode_i;
              rd_active_q <= 1'b1;
              rd_row_q    <= '0;
              rd_col_q    <= '0;
              rd_addr_q   <= '0;
            end else begin
              wr_cnt_q <= wr_cnt_q + 1'b1;
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            // Both scan orders end on the last RAM address
            if (rd_addr_q == LastAddr) begin
              rd_active_q <= 1'b0;
            end else begin
              rd_row_q  <= rd_row_d;
              rd_col_q  <= rd_col_d;
              rd_addr_q <= rd_addr_d;
            end
          end
          if (eof_fire) begin
            state_q      <= WRITE;
            frame_done_q <= 1'b1;
            wr_cnt_q     <= '0;
            in_ready_q   <= 1'b1;
          end
        end
        default: state_q <= WRITE;
      endcase
    end
  end

  // 2-entry output buffer fed by the RAM read port; head entry drives the outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_q    <= 1'b0;
      pend_sof_q   <= 1'b0;
      pend_eof_q   <= 1'b0;
      buf_rd_ptr_q <= 1'b0;
      buf_wr_ptr_q <= 1'b0;
      buf_cnt_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_sof_q[i]  <= 1'b0;
        buf_eof_q[i]  <= 1'b0;
      end
    end else begin
      rd_pend_q  <= rd_issue;
      pend_sof_q <= (rd_addr_q == '0);
      pend_eof_q <= (rd_addr_q == LastAddr);
      if (rd_pend_q) begin
        buf_data_q[buf_wr_ptr_q] <= ram_rdata;
        buf_sof_q[buf_wr_ptr_q]  <= pend_sof_q;
        buf_eof_q[buf_wr_ptr_q]  <= pend_eof_q;
        buf_wr_ptr_q             <= ~buf_wr_ptr_q;
      end
      if (out_fire) begin
        buf_rd_ptr_q <= ~buf_rd_ptr_q;
      end
      buf_cnt_q <= buf_cnt_q + {1'b0, rd_pend_q} - {1'b0, out_fire};
    end
  end

  frame_ram #(
    .Depth (N),
    .Width (BYTE_W),
    .AddrW (AddrW)
  ) u_frame_ram (
    .clk       (clk),
    .wr_en_i   (wr_fire),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i (in_data_i),
    .rd_en_i   (rd_issue),
    .rd_addr_i (rd_addr_q),
    .rd_data_o (ram_rdata)
  );

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid;
  assign out_data_o   = buf_data_q[buf_rd_ptr_q];
  assign out_sof_o    = out_valid & buf_sof_q[buf_rd_ptr_q];
  assign out_eof_o    = out_valid & buf_eof_q[buf_rd_ptr_q];
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_vc4_frame_scheduler.sv
// Scoreboard bench for vc4_frame_scheduler: a driver fills frames, a reference model queues
// the expected scan order, and a monitor checks every output transfer.
module tb_vc4_frame_scheduler;
  import vc4_frame_scheduler_pkg::*;

  localparam int unsigned L = c4_Length;
  localparam int unsigned W = c4_Width;
  localparam int unsigned N = L * W;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scan_mode_i = 1'b0;
  logic [7:0] in_data_i = 8'h00;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i = 1'b1;
  logic       out_sof_o;
  logic       out_eof_o;
  logic       frame_done_o;

  int         checks = 0;
  int         failures = 0;
  logic [9:0] exp_q [$];   // {eof, sof, data}
  logic [7:0] frame_mem [N];
  int         out_idx = 0;
  int         frames_out = 0;
  bit         eof_prev = 1'b0;
  bit         rand_ready = 1'b0;
  logic [9:0] e;

  vc4_frame_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_mode_i  (scan_mode_i),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_sof_o    (out_sof_o),
    .out_eof_o    (out_eof_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: output i of a frame comes from RAM address i (row scan) or from
  // row (i mod W), column (i div W) of the stored row-major frame (column scan).
  function automatic void push_frame(input logic col);
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned a;
      a = col ? (i % W) * L + (i / W) : i;
      exp_q.push_back({(i == N - 1), (i == 0), frame_mem[a]});
    end
  endfunction

  // Downstream ready: always high, or a fair coin per cycle
  always @(posedge clk) begin
    #1;
    out_ready_i = rand_ready ? 1'($urandom_range(1)) : 1'b1;
  end

  // Monitor: compare each output transfer with the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      chk("frame_done", int'(frame_done_o), int'(eof_prev));
      if (eof_prev) begin
        chk("valid_after_eof", int'(out_valid_o), 0);
        chk("ready_after_eof", int'(in_ready_o), 1);
      end
      eof_prev = 1'b0;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %0d expected none", out_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", int'(out_data_o), int'(e[7:0]));
          chk("out_sof", int'(out_sof_o), int'(e[8]));
          chk("out_eof", int'(out_eof_o), int'(e[9]));
          out_idx++;
          if (e[9]) begin
            eof_prev = 1'b1;
            out_idx = 0;
            frames_out++;
          end
        end
      end
    end
  end

  // Push one frame; random gaps and random data optional. Checks input/output latency.
  task automatic send_frame(input bit gaps, input bit rand_data);
    int unsigned k = 0;
    int cyc = 0;
    bit v = 1'b0;
    logic [7:0] d = 8'h00;
    @(posedge clk);
    #1;
    while (k < N && cyc < 20000) begin
      if (!v) begin
        v = gaps ? ($urandom_range(3) != 0) : 1'b1;
        d = rand_data ? 8'($urandom) : 8'(k);
      end
      in_valid_i = v;
      in_data_i  = d;
      @(negedge clk);
      if (v && in_ready_o) begin
        frame_mem[k] = d;
        k++;
        v = 1'b0;
        if (k == N) push_frame(scan_mode_i);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("input_count", int'(k), int'(N));
    if (k != N) begin
      in_valid_i = 1'b0;
      return;
    end
    // Keep offering a byte during READ; it must not be taken
    in_valid_i = 1'b1;
    in_data_i  = 8'hEE;
    @(negedge clk);
    chk("ready_low_t1", int'(in_ready_o), 0);
    chk("lat_valid_t1", int'(out_valid_o), 0);
    @(negedge clk);
    chk("ready_low_t2", int'(in_ready_o), 0);
    chk("lat_valid_t1b", int'(out_valid_o), 0);
    @(negedge clk);
    chk("lat_valid_t2", int'(out_valid_o), 1);
    chk("lat_sof_t2", int'(out_sof_o), 1);
    in_valid_i = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int c = 0;
    while (frames_out < n && c < 12000) begin
      @(negedge clk);
      c++;
    end
    chk("frames_completed", frames_out, n);
  endtask

  task automatic wait_out_idx(input int n);
    int c = 0;
    while (out_idx < n && c < 12000) begin
      @(negedge clk);
      c++;
    end
    chk("reached_out_idx", int'(out_idx >= n), 1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready_o), 0);
    chk("rst_out_valid", int'(out_valid_o), 0);
    chk("rst_sof", int'(out_sof_o), 0);
    chk("rst_eof", int'(out_eof_o), 0);
    chk("rst_frame_done", int'(frame_done_o), 0);
    chk("rst_out_data", int'(out_data_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(in_ready_o), 1);

    // Row mode, free-running downstream
    scan_mode_i = row_based;
    send_frame(1'b0, 1'b0);
    wait_frames(1);

    // Column mode, free-running downstream
    scan_mode_i = col_based;
    send_frame(1'b0, 1'b0);
    wait_frames(2);

    // Column mode, random stalls, input gaps and random data
    rand_ready = 1'b1;
    send_frame(1'b1, 1'b1);
    wait_frames(3);
    rand_ready = 1'b0;

    // Row frame with scan mode flipped mid-replay; next frame picks up the new mode
    scan_mode_i = row_based;
    send_frame(1'b0, 1'b0);
    wait_out_idx(100);
    scan_mode_i = col_based;
    wait_frames(4);
    send_frame(1'b1, 1'b0);
    wait_frames(5);

    // Reset in the middle of a replay
    scan_mode_i = row_based;
    send_frame(1'b0, 1'b0);
    wait_out_idx(500);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid_o), 0);
    chk("midrst_sof", int'(out_sof_o), 0);
    chk("midrst_eof", int'(out_eof_o), 0);
    chk("midrst_in_ready", int'(in_ready_o), 0);
    exp_q.delete();
    out_idx = 0;
    eof_prev = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", int'(in_ready_o), 1);

    // Fresh frame after reset, column mode with stalls
    scan_mode_i = col_based;
    rand_ready = 1'b1;
    send_frame(1'b0, 1'b0);
    wait_frames(6);
    rand_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
